// File: rtl/rival_spawner.sv
// Rival car spawner for the scrolling road: spawns, moves, retires and scores two rival slots, detects player overlap.
// Optional macro RIVAL_SPEEDUP_EN: descent speed grows with score (capped at 6 px/frame).
//
// state | meaning
// IDLE  | slots inactive, waiting for start on a frame tick
// RUN   | rivals descend, spawn and retire once per frame tick
// CRASH | positions frozen for CRASH_FRAMES ticks after a collision
module rival_spawner #(
  parameter int ROAD_Y       = 150,
  parameter int ROAD_H       = 240,
  parameter int LANE_X0      = 218,
  parameter int LANE_PITCH   = 32,
  parameter int SPEED        = 2,
  parameter int SPAWN_FRAMES = 45,
  parameter int CRASH_FRAMES = 90
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_end,
  input  logic        start,
  input  logic [9:0]  car_x,
  input  logic [9:0]  car_y,
  output logic [9:0]  rival0_x,
  output logic [9:0]  rival0_y,
  output logic [9:0]  rival1_x,
  output logic [9:0]  rival1_y,
  output logic        rival0_on,
  output logic        rival1_on,
  output logic        collide,
  output logic        crashed,
  output logic [15:0] score
);

  localparam logic [10:0] RETIRE_Y    = 11'(ROAD_Y + ROAD_H - 16);
  localparam logic [9:0]  NEAR_Y      = 10'(ROAD_Y + 32);
  localparam logic [9:0]  START_Y     = 10'(ROAD_Y);
  localparam logic [9:0]  START_X     = 10'(LANE_X0);
  localparam logic [7:0]  SPAWN_LAST  = 8'(SPAWN_FRAMES - 1);
  localparam logic [7:0]  CRASH_LAST  = 8'(CRASH_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, RUN, CRASH} state_t;

  state_t      state, state_nxt;
  logic        fe_q, tick;
  logic [7:0]  lfsr, spawn_cnt, crash_cnt;
  logic [9:0]  rx [2];
  logic [9:0]  ry [2];
  logic [1:0]  ln [2];
  logic [1:0]  on;
  logic [3:0]  speed;
  logic [10:0] y_adv [2];
  logic [1:0]  retire, hit;
  logic        slot_sel, other, spawn_ok;
  logic [1:0]  lane_sel;
  logic [9:0]  spawn_x;

`ifdef RIVAL_SPEEDUP_EN
  logic [15:0] spd_raw;
  assign spd_raw = 16'(SPEED) + {3'b000, score[15:3]};
  assign speed   = (spd_raw > 16'd6) ? 4'd6 : spd_raw[3:0];
`else
  assign speed = 4'(SPEED);
`endif

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      y_adv[i]  = {1'b0, ry[i]} + {7'b0, speed};
      retire[i] = on[i] && (y_adv[i] > RETIRE_Y);
      hit[i]    = on[i]
                  && ({1'b0, car_x} < {1'b0, rx[i]} + 11'd14)
                  && ({1'b0, car_x} + 11'd14 > {1'b0, rx[i]})
                  && ({1'b0, car_y} < {1'b0, ry[i]} + 11'd16)
                  && ({1'b0, car_y} + 11'd16 > {1'b0, ry[i]});
    end
    // lowest free slot wins; decided on pre-tick occupancy so a slot retiring now stays free
    slot_sel = on[0];
    other    = ~slot_sel;
    spawn_ok = ~(on[0] & on[1]);
    lane_sel = lfsr[1:0];
    if (on[other] && ln[other] == lfsr[1:0] && ry[other] < NEAR_Y)
      lane_sel = lfsr[1:0] + 2'd1;
    spawn_x = START_X + 10'(lane_sel) * 10'(LANE_PITCH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (collide) state_nxt = CRASH;
        CRASH:   if (crash_cnt == CRASH_LAST) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    crashed = (state == CRASH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fe_q      <= 1'b0;
      tick      <= 1'b0;
      lfsr      <= 8'hA5;
      spawn_cnt <= '0;
      crash_cnt <= '0;
      collide   <= 1'b0;
      score     <= '0;
      on        <= '0;
      for (int i = 0; i < 2; i++) begin
        rx[i] <= START_X;
        ry[i] <= START_Y;
        ln[i] <= '0;
      end
    end else begin
      fe_q    <= frame_end;
      tick    <= frame_end & ~fe_q;
      lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      collide <= |hit;
      if (tick) begin
        case (state)
          IDLE: if (start) begin
            score     <= '0;
            spawn_cnt <= '0;
          end
          RUN: if (collide) begin
            crash_cnt <= '0;
          end else begin
            for (int i = 0; i < 2; i++) begin
              if (retire[i])  on[i] <= 1'b0;
              else if (on[i]) ry[i] <= y_adv[i][9:0];
            end
            score <= score + 16'(retire[0]) + 16'(retire[1]);
            if (spawn_cnt == SPAWN_LAST) begin
              spawn_cnt <= '0;
              if (spawn_ok) begin
                on[slot_sel] <= 1'b1;
                rx[slot_sel] <= spawn_x;
                ry[slot_sel] <= START_Y;
                ln[slot_sel] <= lane_sel;
              end
            end else begin
              spawn_cnt <= spawn_cnt + 8'd1;
            end
          end
          CRASH: if (crash_cnt == CRASH_LAST) begin
            on        <= '0;
            spawn_cnt <= '0;
          end else begin
            crash_cnt <= crash_cnt + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign rival0_x  = rx[0];
  assign rival0_y  = ry[0];
  assign rival1_x  = rx[1];
  assign rival1_y  = ry[1];
  assign rival0_on = on[0];
  assign rival1_on = on[1];

endmodule

// File: tb/tb_rival_spawner.sv
// Scoreboard bench for rival_spawner: stimulus queues expected frame results, a monitor checks them after each frame.
module tb_rival_spawner;

  logic        clk = 1'b0;
  logic        reset_n, frame_end, start;
  logic [9:0]  car_x, car_y;
  logic [9:0]  rival0_x, rival0_y, rival1_x, rival1_y;
  logic        rival0_on, rival1_on, collide, crashed;
  logic [15:0] score;

  rival_spawner dut (
    .clk(clk), .reset_n(reset_n), .frame_end(frame_end), .start(start),
    .car_x(car_x), .car_y(car_y),
    .rival0_x(rival0_x), .rival0_y(rival0_y), .rival1_x(rival1_x), .rival1_y(rival1_y),
    .rival0_on(rival0_on), .rival1_on(rival1_on),
    .collide(collide), .crashed(crashed), .score(score)
  );

  always #5 clk = ~clk;

  localparam int unsigned M_ON0 = 1, M_Y0 = 2, M_X0L = 4, M_ON1 = 8, M_Y1 = 16,
                          M_CR = 32, M_SC = 64, M_COL = 128, M_RST = 256;
  localparam int unsigned M_BASE = M_ON0 | M_ON1 | M_CR | M_SC | M_COL;

  typedef struct {
    string        name;
    int unsigned  mask;
    logic         on0, on1, cr, col;
    logic [9:0]   y0, y1;
    logic [15:0]  sc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 0;
  logic probe_s = 1'b0;

  function automatic exp_t mk(string n, int unsigned m, logic on0, int y0, logic on1, int y1,
                              logic cr, int sc, logic col);
    exp_t e;
    e.name = n; e.mask = m; e.on0 = on0; e.y0 = 10'(y0); e.on1 = on1; e.y1 = 10'(y1);
    e.cr = cr; e.sc = 16'(sc); e.col = col;
    return e;
  endfunction

  function automatic int in_lane(logic [9:0] x);
    return (x == 10'd218 || x == 10'd250 || x == 10'd282 || x == 10'd314) ? 1 : 0;
  endfunction

  task automatic chk(string n, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", n, act, req, $time);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      chk("scoreboard_underflow", 0, 1);
      return;
    end
    e = q.pop_front();
    if ((e.mask & M_ON0) != 0) chk({e.name, "_on0"}, rival0_on, e.on0);
    if ((e.mask & M_Y0)  != 0) chk({e.name, "_y0"}, rival0_y, e.y0);
    if ((e.mask & M_X0L) != 0) chk({e.name, "_x0lane"}, in_lane(rival0_x), 1);
    if ((e.mask & M_ON1) != 0) chk({e.name, "_on1"}, rival1_on, e.on1);
    if ((e.mask & M_Y1)  != 0) chk({e.name, "_y1"}, rival1_y, e.y1);
    if ((e.mask & M_CR)  != 0) chk({e.name, "_crashed"}, crashed, e.cr);
    if ((e.mask & M_SC)  != 0) chk({e.name, "_score"}, score, e.sc);
    if ((e.mask & M_COL) != 0) chk({e.name, "_collide"}, collide, e.col);
    if ((e.mask & M_RST) != 0) begin
      chk({e.name, "_x0"}, rival0_x, 218);
      chk({e.name, "_x1"}, rival1_x, 218);
      chk({e.name, "_y0r"}, rival0_y, 150);
      chk({e.name, "_y1r"}, rival1_y, 150);
    end
  endtask

  // frame results settle two clk after the raster edge; sample two negedges after frame_end drops
  always @(negedge frame_end) begin
    if (mon_en) begin
      repeat (2) @(negedge clk);
      pop_check();
    end
  end

  always @(posedge probe_s) pop_check();

  task automatic frame(int len, exp_t e);
    q.push_back(e);
    frame_end = 1'b1;
    repeat (len) @(negedge clk);
    frame_end = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic probe(exp_t e);
    q.push_back(e);
    probe_s = 1'b1;
    #1;
    probe_s = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int unsigned m;
    reset_n = 1'b0; frame_end = 1'b0; start = 1'b0; car_x = '0; car_y = '0;
    repeat (3) @(negedge clk);
    mon_en = 1;
    probe(mk("in_reset", M_BASE | M_RST, 0, 150, 0, 150, 0, 0, 0));
    reset_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 10; k++)
      frame(1 + k % 3, mk("idle", M_BASE | M_RST, 0, 150, 0, 150, 0, 0, 0));

    start = 1'b1;
    frame(2, mk("start", M_BASE, 0, 0, 0, 0, 0, 0, 0));
    start = 1'b0;

    // rival0 spawns on run tick 45, rival1 on tick 90; both descend 2 px per tick
    for (int t = 1; t <= 157; t++) begin
      m = M_BASE;
      if (t >= 45) m |= M_Y0 | M_X0L;
      if (t >= 90) m |= M_Y1;
      e = mk("run", m, t >= 45, 150 + 2 * (t - 45), t >= 90, 150 + 2 * (t - 90), 0, 0, 0);
      frame((t == 60 || t == 100) ? 8 : 1 + t % 4, e);
    end

    frame(3, mk("retire", M_BASE | M_Y1, 0, 0, 1, 286, 0, 1, 0));
    frame(1, mk("post_retire", M_BASE | M_Y1, 0, 0, 1, 288, 0, 1, 0));
    frame(2, mk("post_retire", M_BASE | M_Y1, 0, 0, 1, 290, 0, 1, 0));

    car_x = rival1_x;
    car_y = 10'd300;
    probe(mk("col_lag", M_COL, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    probe(mk("col_set", M_COL, 0, 0, 0, 0, 0, 0, 1));

    frame(2, mk("crash_enter", M_BASE | M_Y1, 0, 0, 1, 290, 1, 1, 1));
    for (int c = 1; c <= 89; c++)
      frame(1 + c % 3, mk("crash_hold", M_BASE | M_Y1, 0, 0, 1, 290, 1, 1, 1));
    frame(2, mk("crash_exit", M_BASE, 0, 0, 0, 0, 0, 1, 0));
    car_x = '0; car_y = '0;

    for (int r = 1; r <= 44; r++)
      frame(1 + r % 2, mk("rerun", M_BASE, 0, 0, 0, 0, 0, 1, 0));
    frame(2, mk("respawn", M_BASE | M_Y0 | M_X0L, 1, 150, 0, 0, 0, 1, 0));

    car_x = rival0_x;
    car_y = 10'd160;
    repeat (2) @(negedge clk);
    frame(2, mk("crash2", M_BASE | M_Y0, 1, 150, 0, 0, 1, 1, 1));
    for (int c = 0; c < 5; c++)
      frame(2, mk("crash2_hold", M_BASE | M_Y0, 1, 150, 0, 0, 1, 1, 1));

    reset_n = 1'b0;
    #1;
    probe(mk("rst_mid_crash", M_BASE | M_RST, 0, 150, 0, 150, 0, 0, 0));
    @(negedge clk);
    car_x = '0; car_y = '0;
    reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      frame(2, mk("idle2", M_BASE | M_RST, 0, 150, 0, 150, 0, 0, 0));

    start = 1'b1;
    frame(3, mk("restart", M_BASE, 0, 0, 0, 0, 0, 0, 0));
    start = 1'b0;
    for (int t = 1; t <= 44; t++)
      frame(1, mk("fresh", M_BASE, 0, 0, 0, 0, 0, 0, 0));
    frame(1, mk("fresh_spawn", M_BASE | M_Y0 | M_X0L, 1, 150, 0, 0, 0, 0, 0));

`ifdef RIVAL_SPEEDUP_EN
    begin
      int guard;
      bit found;
      int slot;
      guard = 0; found = 0; slot = 0;
      while (!found && guard < 6000) begin
        frame(1, mk("spd_hunt", 0, 0, 0, 0, 0, 0, 0, 0));
        guard++;
        if (score >= 16 && score <= 20) begin
          if (rival0_on && rival0_y == 10'd150)      begin found = 1; slot = 0; end
          else if (rival1_on && rival1_y == 10'd150) begin found = 1; slot = 1; end
        end
      end
      chk("spd_spawn_found", int'(found), 1);
      if (found) begin
        for (int k = 1; k <= 3; k++)
          frame(1, mk("spd_descent", (slot == 0) ? M_Y0 : M_Y1,
                      0, 150 + 4 * k, 0, 150 + 4 * k, 0, 0, 0));
      end
    end
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
